bcd_display_scanner: RTL and testbench

Multiplexed four-digit seven-segment driver that sits directly downstream of the BCD counters and consumes their 4-bit digit outputs. It captures a 16-bit BCD word into a shadow register and time-multiplexes the four digits onto one active-low segment bus with active-low digit enables. It optionally blanks leading zeros and shows a dash for any non-BCD nibble.

---
 rtl/bcd_disp_pkg.sv | 27 ++
 rtl/bcd_display_scanner_if.sv | 24 ++
 rtl/seven_seg_decode.sv | 32 +++
 rtl/bcd_display_scanner.sv | 74 +++++++
 tb/tb_bcd_display_scanner.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the seven-segment display blocks: active-low
// segment patterns {g,f,e,d,c,b,a} and digit-enable helpers.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'hF;

  // Active-low enable with only the selected digit driven low.
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [1:0] idx);
    return AN_ALL_OFF ^ (4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Display bus between the BCD source / board pins and the scanner.
// Data side: bcd_in is captured when load is high on a rising clock edge;
// there is no back-pressure, the scanner accepts every load.
interface bcd_display_scanner_if;
  import bcd_disp_pkg::*;

  logic [15:0]           bcd_in;
  logic                  load;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  frame;

  modport master (
    output bcd_in, load, blank_lz,
    input  an, seg, frame
  );

  modport slave (
    input  bcd_in, load, blank_lz,
    output an, seg, frame
  );

endinterface

// File: rtl/seven_seg_decode.sv
// Nibble to active-low seven-segment pattern; non-BCD nibbles show a dash,
// and blank overrides everything with all segments off.
module seven_seg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    if (blank) begin
      pattern = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed seven-segment driver: shadows a BCD word and scans
// one digit per SCAN_DIV cycles onto active-low an/seg, with a frame pulse.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input logic                 clock,
  input logic                 reset,
  bcd_display_scanner_if.slave bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]  presc;
  logic [1:0]     idx;
  logic [1:0]     idx_next;
  logic [15:0]    shadow;
  logic           wrap;
  logic [3:0]     blank_vec;
  logic [3:0]     nibble;
  logic [6:0]     seg_next;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]     seg_q;
  logic           frame_q;

  always_comb begin
    wrap     = (presc == PW'(SCAN_DIV - 1));
    idx_next = wrap ? idx + 2'd1 : idx;
  end

  // A digit is blanked only when it and every more significant digit are
  // zero; any non-zero nibble (including a dash) ends the blanked run.
  always_comb begin
    blank_vec    = 4'b0000;
    blank_vec[1] = bus.blank_lz && (shadow[15:4] == 12'h000);
    blank_vec[2] = bus.blank_lz && (shadow[15:8] == 8'h00);
    blank_vec[3] = bus.blank_lz && (shadow[15:12] == 4'h0);
    nibble       = shadow[{idx_next, 2'b00} +: 4];
  end

  seven_seg_decode u_decode (
    .nibble  (nibble),
    .blank   (blank_vec[idx_next]),
    .pattern (seg_next)
  );

  // Outputs are computed from the pre-edge shadow, so a load coinciding
  // with an advance shows up one edge later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      idx     <= 2'd0;
      shadow  <= 16'h0000;
      an_q    <= an_select(2'd0);
      seg_q   <= SEG_0;
      frame_q <= 1'b0;
    end else begin
      presc   <= wrap ? '0 : presc + PW'(1);
      idx     <= idx_next;
      an_q    <= an_select(idx_next);
      seg_q   <= seg_next;
      frame_q <= wrap && (idx == 2'd3);
      if (bus.load) begin
        shadow <= bus.bcd_in;
      end
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: directed scenarios followed by random loads
// and blanking, compared against an arithmetic model of the display.
module tb_bcd_display_scanner;

  localparam int SCAN_DIV = 4;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bcd_display_scanner_if vif ();

  bcd_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif.slave)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: edges since reset release and the shadowed word.
  int          m_edges;
  logic [15:0] m_shadow;
  int          m_idx;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_frame;

  function automatic logic [6:0] ref_seg(input logic [15:0] word, input logic blz,
                                         input int k);
    logic [6:0] tab [10];
    int d;
    int upper;
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    upper = int'(word) >> (4 * k);
    d = upper % 16;
    if (blz && k != 0 && upper == 0) return 7'h7F;
    if (d > 9) return 7'h3F;
    return tab[d];
  endfunction

  function automatic logic [6:0] rand_nib();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 7'd0;
    if (r < 8) return 7'($urandom_range(1, 9));
    return 7'($urandom_range(10, 15));
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    logic [6:0]  n;
    w = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      n = rand_nib();
      w[4*i +: 4] = n[3:0];
    end
    return w;
  endfunction

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges  = 0;
    m_shadow = 16'h0000;
    m_idx    = 0;
  endtask

  // Driver: apply inputs, clock one edge, advance the model, compare.
  task automatic tick(input logic ld, input logic [15:0] d, input logic blz);
    vif.load     = ld;
    vif.bcd_in   = d;
    vif.blank_lz = blz;
    @(posedge clock);
    m_edges++;
    m_idx     = (m_edges / SCAN_DIV) % 4;
    exp_an    = ~(4'b0001 << m_idx);
    exp_seg   = ref_seg(m_shadow, blz, m_idx);
    exp_frame = (m_edges % (4 * SCAN_DIV)) == 0;
    if (ld) m_shadow = d;
    #1;
    chk4("an", vif.an, exp_an);
    chk7("seg", vif.seg, exp_seg);
    chk1("frame", vif.frame, exp_frame);
  endtask

  task automatic check_reset_vals(input string tag);
    chk4({tag, "_an"}, vif.an, 4'b1110);
    chk7({tag, "_seg"}, vif.seg, 7'h40);
    chk1({tag, "_frame"}, vif.frame, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    vif.load     = 1'b0;
    vif.bcd_in   = 16'h0000;
    vif.blank_lz = 1'b0;
    model_reset();

    // Reset held: outputs stay at reset values across edges, even with load.
    for (int i = 0; i < 3; i++) begin
      vif.load   = 1'b1;
      vif.bcd_in = 16'h8888;
      @(posedge clock);
      #1;
      check_reset_vals("in_reset");
    end
    vif.load = 1'b0;
    #2;
    reset = 1'b1;

    // Plain scan: an steps at edges 4/8/12/16, frame after edge 16.
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) tick(1'b0, 16'h0000, 1'b0);

    // 0x1234 without blanking.
    tick(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 4 * SCAN_DIV + 1; i++) tick(1'b0, 16'h0000, 1'b0);

    // 0x0050 with and without blanking.
    tick(1'b1, 16'h0050, 1'b1);
    for (int i = 0; i < 4 * SCAN_DIV + 1; i++) tick(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 4 * SCAN_DIV; i++) tick(1'b0, 16'h0000, 1'b0);

    // 0x0A00: dash stops the blanked run.
    tick(1'b1, 16'h0A00, 1'b1);
    for (int i = 0; i < 4 * SCAN_DIV + 1; i++) tick(1'b0, 16'h0000, 1'b1);

    // Load 0x9999 on an advancing edge: old digit first, 0x10 next edge.
    while (((m_edges + 1) % SCAN_DIV) != 0) tick(1'b0, 16'h0000, 1'b0);
    tick(1'b1, 16'h9999, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    chk7("seg_after_9999", vif.seg, 7'h10);
    for (int i = 0; i < 4 * SCAN_DIV; i++) tick(1'b0, 16'h0000, 1'b0);

    // Load held high captures every cycle.
    for (int i = 0; i < 2 * SCAN_DIV; i++) tick(1'b1, rand_word(), 1'b0);

    // Asynchronous reset mid-frame at digit 2.
    tick(1'b1, 16'h4321, 1'b0);
    while (m_idx != 2) tick(1'b0, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(posedge clock);
    #1;
    check_reset_vals("async_reset_held");
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4 * SCAN_DIV + 4; i++) tick(1'b0, 16'h0000, 1'b0);

    // Random loads, words with zeros and invalid nibbles, toggling blanking.
    begin
      logic blz;
      blz = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 7) == 0) blz = ~blz;
        tick(($urandom_range(0, 3) == 0), rand_word(), blz);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
